// File: rtl/read_tick_sequencer_pkg.sv
// Shared constants for the read tick sequencer: FSM state encoding,
// default widths, and the nominal tick period of the divided read clock.
package read_tick_sequencer_pkg;

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] WAIT_TICK = 2'd1;
    localparam logic [1:0] READ      = 2'd2;
    localparam logic [1:0] CAPTURE   = 2'd3;

    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_DATA_WIDTH = 16;

    // Cycles of the 50 MHz clock per SLOW_CLK period when fed by the divider.
    localparam int TICK_PERIOD = 512;

    localparam logic [7:0] OVR_CNT_MAX = 8'hFF;

endpackage

// File: rtl/read_tick_sync.sv
// Brings the asynchronous divided read clock into the 50 MHz domain and turns
// each rising edge into a single-cycle TICK.
module read_tick_sync (
    input  logic IN_50Mhz,
    input  logic RESET_N,
    input  logic SLOW_CLK,
    output logic TICK
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;
    logic s3_q, s3_d;

    always_comb begin
        s1_d = SLOW_CLK;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    always_ff @(posedge IN_50Mhz or negedge RESET_N) begin
        if (!RESET_N) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    // s3 only serves as edge history; s1 is never used as a data input.
    assign TICK = s2_q & ~s3_q;

endmodule

// File: rtl/read_tick_sequencer.sv
// Reads LENGTH words from BASE_ADDR, one per SLOW_CLK rising edge, and offers
// them on a valid/ready port. Define READ_TICK_SEQ_OVERRUN_CNT_EN for OVERRUN_CNT.
module read_tick_sequencer
    import read_tick_sequencer_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  IN_50Mhz,
    input  logic                  RESET_N,
    input  logic                  SLOW_CLK,
    input  logic                  START,
    input  logic [ADDR_WIDTH-1:0] BASE_ADDR,
    input  logic [ADDR_WIDTH-1:0] LENGTH,
    output logic                  RD_EN,
    output logic [ADDR_WIDTH-1:0] RD_ADDR,
    input  logic [DATA_WIDTH-1:0] RD_DATA,
    output logic [DATA_WIDTH-1:0] OUT_DATA,
    output logic                  OUT_VALID,
    input  logic                  OUT_READY,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  OVERRUN
`ifdef READ_TICK_SEQ_OVERRUN_CNT_EN
    ,
    output logic [7:0]            OVERRUN_CNT
`endif
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;

    logic tick;

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [ADDR_WIDTH-1:0] len_q, len_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;
    logic                  done_q, done_d;
    logic                  overrun_q, overrun_d;
    logic [ADDR_WIDTH-1:0] idx_inc;

    read_tick_sync u_sync (
        .IN_50Mhz (IN_50Mhz),
        .RESET_N  (RESET_N),
        .SLOW_CLK (SLOW_CLK),
        .TICK     (tick)
    );

    assign idx_inc = idx_q + ADDR_ONE;

`ifdef READ_TICK_SEQ_OVERRUN_CNT_EN
    logic [7:0] ovr_cnt_q, ovr_cnt_d;
    logic       ovr_clear;
    logic       ovr_skip;

    always_comb begin
        ovr_cnt_d = ovr_cnt_q;
        if (ovr_clear) begin
            ovr_cnt_d = 8'h00;
        end else if (ovr_skip && ovr_cnt_q != OVR_CNT_MAX) begin
            ovr_cnt_d = ovr_cnt_q + 8'h01;
        end
    end

    always_ff @(posedge IN_50Mhz or negedge RESET_N) begin
        if (!RESET_N) begin
            ovr_cnt_q <= 8'h00;
        end else begin
            ovr_cnt_q <= ovr_cnt_d;
        end
    end

    assign ovr_clear   = (state_q == IDLE) && START;
    assign ovr_skip    = (state_q == WAIT_TICK) && tick && out_valid_q && !OUT_READY;
    assign OVERRUN_CNT = ovr_cnt_q;
`endif

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        len_d       = len_q;
        idx_d       = idx_q;
        rd_addr_d   = rd_addr_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        done_d      = 1'b0;
        overrun_d   = overrun_q;

        // A handshake empties the output unless CAPTURE refills it below.
        if (out_valid_q && OUT_READY) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (START) begin
                    base_d    = BASE_ADDR;
                    len_d     = LENGTH;
                    idx_d     = '0;
                    overrun_d = 1'b0;
                    if (LENGTH == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = WAIT_TICK;
                    end
                end
            end
            WAIT_TICK: begin
                if (tick) begin
                    if (out_valid_q && !OUT_READY) begin
                        overrun_d = 1'b1;
                    end else begin
                        state_d   = READ;
                        rd_addr_d = base_q + idx_q;
                    end
                end
            end
            READ: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                out_data_d  = RD_DATA;
                out_valid_d = 1'b1;
                idx_d       = idx_inc;
                if (idx_inc == len_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = WAIT_TICK;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge IN_50Mhz or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= IDLE;
            base_q      <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            rd_addr_q   <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            rd_addr_q   <= rd_addr_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
            overrun_q   <= overrun_d;
        end
    end

    assign RD_EN     = (state_q == READ);
    assign RD_ADDR   = rd_addr_q;
    assign OUT_DATA  = out_data_q;
    assign OUT_VALID = out_valid_q;
    assign BUSY      = (state_q != IDLE);
    assign DONE      = done_q;
    assign OVERRUN   = overrun_q;

endmodule

// File: tb/tb_read_tick_sequencer.sv
// Bench for read_tick_sequencer: event-scheduled transfer model checked every
// cycle, plus directed scenarios with hand-computed addresses and data words.
module tb_read_tick_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        slow_clk = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  base_addr = 8'h00;
    logic [7:0]  length = 8'h00;
    logic        rd_en;
    logic [7:0]  rd_addr;
    logic [15:0] rd_data = 16'h0000;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        busy;
    logic        done;
    logic        overrun;
`ifdef READ_TICK_SEQ_OVERRUN_CNT_EN
    logic [7:0]  overrun_cnt;
`endif

    int tests = 0;
    int fails = 0;

    read_tick_sequencer dut (
        .IN_50Mhz  (clk),
        .RESET_N   (rst_n),
        .SLOW_CLK  (slow_clk),
        .START     (start),
        .BASE_ADDR (base_addr),
        .LENGTH    (length),
        .RD_EN     (rd_en),
        .RD_ADDR   (rd_addr),
        .RD_DATA   (rd_data),
        .OUT_DATA  (out_data),
        .OUT_VALID (out_valid),
        .OUT_READY (out_ready),
        .BUSY      (busy),
        .DONE      (done),
        .OVERRUN   (overrun)
`ifdef READ_TICK_SEQ_OVERRUN_CNT_EN
        ,
        .OVERRUN_CNT (overrun_cnt)
`endif
    );

    initial forever #10 clk = ~clk;

    // Divider stand-in: 512-cycle square wave, edges placed away from clk rise.
    initial forever begin
        repeat (256) @(negedge clk);
        slow_clk = ~slow_clk;
    end

    // Memory content: word at address a is {a ^ 8'h5A, a}.
    logic [15:0] mem [256];
    initial begin
        for (int a = 0; a < 256; a++) begin
            mem[a] = {8'(a) ^ 8'h5A, 8'(a)};
        end
    end

    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // ------------------------------------------------------------------
    // Transfer model: ticks are SLOW_CLK rises seen two samples late; an
    // accepted tick puts the read in the next cycle and the word on the
    // output two edges after that.
    // ------------------------------------------------------------------
    int          cyc = 0;
    logic [2:0]  hist = '0;
    bit          m_busy = 0, m_inflight = 0, m_valid = 0, m_done = 0, m_ovr = 0;
    int          m_cnt = 0, m_idx = 0, m_len = 0, m_base = 0;
    int          m_rd_cycle = -1, m_cap_cycle = -1;
    logic [7:0]  m_addr = '0;
    logic [15:0] m_data = '0;

    logic [7:0]  rd_q[$];
    logic [15:0] out_q[$];
    int          done_cnt = 0;

    always @(posedge clk or negedge rst_n) begin
        bit tick_now, waiting, busy_pre, valid_pre;
        if (!rst_n) begin
            hist = '0;
            m_busy = 0; m_inflight = 0; m_valid = 0; m_done = 0; m_ovr = 0;
            m_cnt = 0; m_idx = 0; m_rd_cycle = -1; m_cap_cycle = -1;
        end else begin
            cyc++;
            if (rd_en) rd_q.push_back(rd_addr);
            if (out_valid && out_ready) out_q.push_back(out_data);
            if (done) done_cnt++;

            tick_now  = hist[1] & ~hist[2];
            waiting   = m_busy && !m_inflight;
            busy_pre  = m_busy;
            valid_pre = m_valid;
            m_done    = 0;

            if (m_inflight && cyc == m_cap_cycle) begin
                m_valid    = 1;
                m_data     = mem[m_addr];
                m_inflight = 0;
                m_idx++;
                if (m_idx == m_len) begin
                    m_busy = 0;
                    m_done = 1;
                end
            end else if (valid_pre && out_ready) begin
                m_valid = 0;
            end

            if (waiting && tick_now) begin
                if (valid_pre && !out_ready) begin
                    m_ovr = 1;
                    if (m_cnt < 255) m_cnt++;
                end else begin
                    m_inflight  = 1;
                    m_rd_cycle  = cyc;
                    m_cap_cycle = cyc + 2;
                    m_addr      = 8'(m_base + m_idx);
                end
            end

            if (!busy_pre && start) begin
                m_base = int'(base_addr);
                m_len  = int'(length);
                m_idx  = 0;
                m_ovr  = 0;
                m_cnt  = 0;
                if (length == 8'h00) m_done = 1;
                else m_busy = 1;
            end

            hist = {hist[1:0], slow_clk};
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("busy", 32'(busy), 32'(m_busy));
            check("done", 32'(done), 32'(m_done));
            check("overrun", 32'(overrun), 32'(m_ovr));
            check("out_valid", 32'(out_valid), 32'(m_valid));
            check("rd_en", 32'(rd_en), 32'(cyc == m_rd_cycle));
            if (cyc == m_rd_cycle) check("rd_addr", 32'(rd_addr), 32'(m_addr));
            if (m_valid) check("out_data", 32'(out_data), 32'(m_data));
`ifdef READ_TICK_SEQ_OVERRUN_CNT_EN
            check("overrun_cnt", 32'(overrun_cnt), 32'(m_cnt));
`endif
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic do_start(input logic [7:0] b, input logic [7:0] l);
        @(negedge clk);
        start = 1'b1;
        base_addr = b;
        length = l;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int max, input string name);
        int n = 0;
        while (!done && n < max) begin
            @(negedge clk);
            n++;
        end
        if (n >= max) check({name, "_timeout"}, 32'(done), 32'd1);
    endtask

    task automatic wait_valid(input int max, input string name);
        int n = 0;
        while (!out_valid && n < max) begin
            @(negedge clk);
            n++;
        end
        if (n >= max) check({name, "_timeout"}, 32'(out_valid), 32'd1);
    endtask

    task automatic wait_words(input int cnt, input int max, input string name);
        int n = 0;
        while (out_q.size() < cnt && n < max) begin
            @(negedge clk);
            n++;
        end
        if (n >= max) check({name, "_timeout"}, 32'(out_q.size()), 32'(cnt));
    endtask

    task automatic clear_logs();
        rd_q.delete();
        out_q.delete();
        done_cnt = 0;
    endtask

    initial begin
        // Reset with SLOW_CLK running, then idle without START.
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_rd_en", 32'(rd_en), 32'd0);
        repeat (600) @(negedge clk);
        check("idle_no_reads", 32'(rd_q.size()), 32'd0);
        $display("[TB] reset/idle: reads=%0d", rd_q.size());

        // Basic transfer.
        out_ready = 1'b1;
        clear_logs();
        do_start(8'h10, 8'd3);
        wait_done(3000, "basic");
        repeat (3) @(negedge clk);
        check("basic_nreads", 32'(rd_q.size()), 32'd3);
        check("basic_addr0", 32'(rd_q[0]), 32'h10);
        check("basic_addr1", 32'(rd_q[1]), 32'h11);
        check("basic_addr2", 32'(rd_q[2]), 32'h12);
        check("basic_word0", 32'(out_q[0]), 32'h4A10);
        check("basic_word1", 32'(out_q[1]), 32'h4B11);
        check("basic_word2", 32'(out_q[2]), 32'h4812);
        check("basic_done_cnt", 32'(done_cnt), 32'd1);
        $display("[TB] basic: reads=%0d words=%0d dones=%0d", rd_q.size(), out_q.size(), done_cnt);

        // Address wrap.
        clear_logs();
        do_start(8'hFE, 8'd4);
        wait_done(4000, "wrap");
        repeat (3) @(negedge clk);
        check("wrap_addr0", 32'(rd_q[0]), 32'hFE);
        check("wrap_addr1", 32'(rd_q[1]), 32'hFF);
        check("wrap_addr2", 32'(rd_q[2]), 32'h00);
        check("wrap_addr3", 32'(rd_q[3]), 32'h01);
        check("wrap_word2", 32'(out_q[2]), 32'h5A00);
        $display("[TB] wrap: reads=%0d words=%0d", rd_q.size(), out_q.size());

        // Backpressure across two ticks.
        out_ready = 1'b0;
        clear_logs();
        do_start(8'h20, 8'd3);
        wait_valid(1200, "bp_first");
        repeat (1100) @(negedge clk);
        check("bp_overrun", 32'(overrun), 32'd1);
        check("bp_nreads", 32'(rd_q.size()), 32'd1);
        check("bp_held_data", 32'(out_data), 32'h7A20);
        check("bp_held_valid", 32'(out_valid), 32'd1);
`ifdef READ_TICK_SEQ_OVERRUN_CNT_EN
        check("bp_overrun_cnt", 32'(overrun_cnt), 32'd2);
`endif
        out_ready = 1'b1;
        wait_done(3000, "bp");
        repeat (3) @(negedge clk);
        check("bp_resume_addr", 32'(rd_q[1]), 32'h21);
        check("bp_total_reads", 32'(rd_q.size()), 32'd3);
        check("bp_word1", 32'(out_q[1]), 32'h7B21);
        $display("[TB] backpressure: reads=%0d words=%0d", rd_q.size(), out_q.size());

        // LENGTH=0: DONE in the cycle after START, no read.
        clear_logs();
        do_start(8'h30, 8'd0);
        check("len0_done", 32'(done), 32'd1);
        check("len0_busy", 32'(busy), 32'd0);
        repeat (600) @(negedge clk);
        check("len0_nreads", 32'(rd_q.size()), 32'd0);
        $display("[TB] len0: dones=%0d reads=%0d", done_cnt, rd_q.size());

        // START while busy is ignored.
        clear_logs();
        do_start(8'h40, 8'd2);
        repeat (50) @(negedge clk);
        do_start(8'h80, 8'd5);
        wait_done(3000, "busy_start");
        repeat (600) @(negedge clk);
        check("bstart_nreads", 32'(rd_q.size()), 32'd2);
        check("bstart_addr1", 32'(rd_q[1]), 32'h41);
        check("bstart_dones", 32'(done_cnt), 32'd1);
        $display("[TB] busy start: reads=%0d dones=%0d", rd_q.size(), done_cnt);

        // Reset in the middle of a 5-word transfer with a word pending.
        clear_logs();
        do_start(8'h60, 8'd5);
        wait_words(2, 3000, "mid_words");
        out_ready = 1'b0;
        wait_valid(1200, "mid_valid");
        check("mid_pre_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_rd_en", 32'(rd_en), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (1200) @(negedge clk);
        check("mid_no_done", 32'(done_cnt), 32'd0);
        check("mid_nreads", 32'(rd_q.size()), 32'd3);
        $display("[TB] reset mid-transfer: reads=%0d dones=%0d", rd_q.size(), done_cnt);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
